conv_layer_scheduler: RTL and testbench

//   Multi-layer sequencer above pe_controller. Holds a small descriptor table (one entry per conv layer),

---
 rtl/conv_layer_scheduler_pkg.sv | 37 +++
 rtl/conv_layer_scheduler_if.sv | 25 ++
 rtl/conv_layer_scheduler_div_unit.sv | 46 ++++
 rtl/conv_layer_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_layer_scheduler_pkg.sv
// Shared types for the conv layer scheduler: FSM states, error codes and descriptor layout.
package conv_sched_pkg;

   localparam int DESC_W = 64;
   localparam int SPAN_W = 11;
   localparam int QUO_W  = 9;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_CALC_H, S_CALC_W, S_CHECK,
      S_LAUNCH, S_RUN, S_WB, S_NEXT, S_DONE, S_ERROR
   } sched_state_e;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_STRIDE = 2'd1;
   localparam logic [1:0] ERR_KERNEL = 2'd2;
   localparam logic [1:0] ERR_ACC    = 2'd3;

   // Field order matches cfg_wdata, MSB first.
   typedef struct packed {
      logic [15:0] input_base;
      logic [15:0] weight_base;
      logic [7:0]  input_w;
      logic [7:0]  input_h;
      logic [3:0]  padding;
      logic [3:0]  stride;
      logic [3:0]  kernel_w;
      logic [3:0]  kernel_h;
   } desc_t;

   // Padded input minus kernel; negative means the kernel does not fit.
   function automatic logic signed [SPAN_W-1:0] calc_span(input logic [7:0] inp,
                                                          input logic [3:0] pad,
                                                          input logic [3:0] k);
      return $signed({3'b0, inp}) + $signed({6'b0, pad, 1'b0}) - $signed({7'b0, k});
   endfunction

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Scheduler <-> pe_controller / writeback link: layer config, launch/done and drain handshake.
interface conv_layer_scheduler_if;
   logic        pe_start;
   logic        pe_done;
   logic [3:0]  pe_kernel_h, pe_kernel_w, pe_stride, pe_padding;
   logic [7:0]  pe_input_h, pe_input_w, pe_output_h, pe_output_w;
   logic [15:0] weight_base, input_base;
   logic        wb_req;
   logic        wb_ack;
   logic [9:0]  wb_count;

   modport master (
      output pe_start, pe_kernel_h, pe_kernel_w, pe_stride, pe_padding,
             pe_input_h, pe_input_w, pe_output_h, pe_output_w,
             weight_base, input_base, wb_req, wb_count,
      input  pe_done, wb_ack
   );

   modport slave (
      input  pe_start, pe_kernel_h, pe_kernel_w, pe_stride, pe_padding,
             pe_input_h, pe_input_w, pe_output_h, pe_output_w,
             weight_base, input_base, wb_req, wb_count,
      output pe_done, wb_ack
   );
endinterface

// File: rtl/conv_layer_scheduler_div_unit.sv
// Repeated-subtraction divider, one subtraction per cycle; shared for output height and width.
module sched_div_unit #(
   parameter int DW = 11,
   parameter int QW = 9
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [3:0]    divisor,
   output logic          busy,
   output logic          last,
   output logic [QW-1:0] quotient,
   output logic          ovf
);
   logic [DW-1:0] rem;
   logic [DW-1:0] dvs;

   assign dvs  = DW'(divisor);
   // While busy, last marks the cycle on which quotient is final.
   assign last = rem < dvs;
   // Output is quotient+1, so 255 or more no longer fits 8 bits.
   assign ovf  = quotient >= QW'(255);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         quotient <= '0;
         busy     <= 1'b0;
      end else if (clr) begin
         busy <= 1'b0;
      end else if (start) begin
         rem      <= dividend;
         quotient <= '0;
         busy     <= 1'b1;
      end else if (busy) begin
         if (last) begin
            busy <= 1'b0;
         end else begin
            rem      <= rem - dvs;
            quotient <= quotient + QW'(1);
         end
      end
   end
endmodule

// File: rtl/conv_layer_scheduler.sv
// Multi-layer sequencer: walks the descriptor table, sizes each layer, launches pe_controller, drains results.
module conv_layer_scheduler
   import conv_sched_pkg::*;
#(
   parameter  int MAX_LAYERS = 8,
   parameter  int ACC_DEPTH  = 1024,
   localparam int AW         = $clog2(MAX_LAYERS)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [DESC_W-1:0] cfg_wdata,
   input  logic [3:0]        num_layers,
   input  logic              sched_start,
   input  logic              sched_abort,
   output logic              busy,
   output logic              sched_done,
   output logic              sched_err,
   output logic [1:0]        err_code,
   output logic [AW-1:0]     err_layer,
   output logic [AW-1:0]     cur_layer,
   conv_layer_scheduler_if.master pe_if
);
   sched_state_e state;
   desc_t        desc_tbl [MAX_LAYERS];
   desc_t        d_cur;
   logic [3:0]   n_layers;
   logic         pe_done_q, start_acc;

   logic [3:0]   kh, kw, stride_r, pad_r;
   logic [7:0]   ih, iw, out_h, out_w;
   logic [15:0]  wbase, ibase, prod;
   logic         ovf_h, ovf_w, pe_start_r, wb_req_r;
   logic [9:0]   wb_count_r;
   logic [1:0]   chk_err;

   logic signed [SPAN_W-1:0] n_h_tbl, n_h_r, n_w_r;
   logic                     bad_h_tbl, bad_h, bad_w;
   logic                     div_start, div_busy, div_last, div_ovf;
   logic [SPAN_W-1:0]        div_n;
   logic [3:0]               div_d;
   logic [QUO_W-1:0]         div_q;

   assign start_acc = (state == S_IDLE) && sched_start &&
                      (num_layers != 4'd0) && (int'(num_layers) <= MAX_LAYERS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_LAYERS; i++) desc_tbl[i] <= '0;
      end else if (cfg_we && !busy && !start_acc) begin
         desc_tbl[cfg_addr] <= desc_t'(cfg_wdata);
      end
   end

   assign d_cur     = desc_tbl[cur_layer];
   assign n_h_tbl   = calc_span(d_cur.input_h, d_cur.padding, d_cur.kernel_h);
   assign bad_h_tbl = (d_cur.stride == 4'd0) || (n_h_tbl < 0);
   assign n_h_r     = calc_span(ih, pad_r, kh);
   assign n_w_r     = calc_span(iw, pad_r, kw);
   assign bad_h     = (stride_r == 4'd0) || (n_h_r < 0);
   assign bad_w     = n_w_r < 0;

   // Height division starts as the descriptor is fetched; width starts on the cycle height finishes.
   assign div_start = ((state == S_FETCH) && !bad_h_tbl) ||
                      ((state == S_CALC_H) && !bad_h && div_busy && div_last && !bad_w);
   assign div_n     = (state == S_FETCH) ? n_h_tbl : n_w_r;
   assign div_d     = (state == S_FETCH) ? d_cur.stride : stride_r;

   sched_div_unit #(.DW(SPAN_W), .QW(QUO_W)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sched_abort),
      .start    (div_start),
      .dividend (div_n),
      .divisor  (div_d),
      .busy     (div_busy),
      .last     (div_last),
      .quotient (div_q),
      .ovf      (div_ovf)
   );

   assign prod = 16'(out_h) * 16'(out_w);

   always_comb begin
      chk_err = ERR_NONE;
      if (stride_r == 4'd0)                              chk_err = ERR_STRIDE;
      else if (bad_h || bad_w)                           chk_err = ERR_KERNEL;
      else if (ovf_h || ovf_w || int'(prod) > ACC_DEPTH) chk_err = ERR_ACC;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         sched_done <= 1'b0;
         sched_err  <= 1'b0;
         err_code   <= ERR_NONE;
         err_layer  <= '0;
         cur_layer  <= '0;
         n_layers   <= '0;
         pe_done_q  <= 1'b0;
         pe_start_r <= 1'b0;
         wb_req_r   <= 1'b0;
         wb_count_r <= '0;
         {kh, kw, stride_r, pad_r} <= '0;
         {ih, iw, out_h, out_w}    <= '0;
         {wbase, ibase}            <= '0;
         {ovf_h, ovf_w}            <= '0;
      end else begin
         pe_done_q  <= pe_if.pe_done;
         pe_start_r <= 1'b0;
         sched_done <= 1'b0;
         sched_err  <= 1'b0;
         if (sched_abort && state != S_IDLE) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            wb_req_r <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: if (start_acc) begin
                  state     <= S_FETCH;
                  busy      <= 1'b1;
                  cur_layer <= '0;
                  err_code  <= ERR_NONE;
                  err_layer <= '0;
                  n_layers  <= num_layers;
               end
               S_FETCH: begin
                  kh       <= d_cur.kernel_h;
                  kw       <= d_cur.kernel_w;
                  stride_r <= d_cur.stride;
                  pad_r    <= d_cur.padding;
                  ih       <= d_cur.input_h;
                  iw       <= d_cur.input_w;
                  wbase    <= d_cur.weight_base;
                  ibase    <= d_cur.input_base;
                  {out_h, out_w, ovf_h, ovf_w} <= '0;
                  state    <= S_CALC_H;
               end
               S_CALC_H: begin
                  if (bad_h) begin
                     state <= S_CHECK;
                  end else if (div_busy && div_last) begin
                     out_h <= div_ovf ? 8'hFF : div_q[7:0] + 8'd1;
                     ovf_h <= div_ovf;
                     state <= bad_w ? S_CHECK : S_CALC_W;
                  end
               end
               S_CALC_W: begin
                  if (div_busy && div_last) begin
                     out_w <= div_ovf ? 8'hFF : div_q[7:0] + 8'd1;
                     ovf_w <= div_ovf;
                     state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (chk_err != ERR_NONE) begin
                     state     <= S_ERROR;
                     sched_err <= 1'b1;
                     busy      <= 1'b0;
                     err_code  <= chk_err;
                     err_layer <= cur_layer;
                  end else begin
                     state      <= S_LAUNCH;
                     pe_start_r <= 1'b1;
                     wb_count_r <= 10'(prod - 16'd1);
                  end
               end
               S_LAUNCH: state <= S_RUN;
               // Only a fresh rising edge counts; a level left over from the last layer does not.
               S_RUN: if (pe_if.pe_done && !pe_done_q) begin
                  state    <= S_WB;
                  wb_req_r <= 1'b1;
               end
               S_WB: if (pe_if.wb_ack) begin
                  state    <= S_NEXT;
                  wb_req_r <= 1'b0;
               end
               S_NEXT: begin
                  if (int'(cur_layer) == int'(n_layers) - 1) begin
                     state      <= S_DONE;
                     sched_done <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     cur_layer <= cur_layer + AW'(1);
                     state     <= S_FETCH;
                  end
               end
               S_DONE, S_ERROR: state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign pe_if.pe_start    = pe_start_r;
   assign pe_if.pe_kernel_h = kh;
   assign pe_if.pe_kernel_w = kw;
   assign pe_if.pe_stride   = stride_r;
   assign pe_if.pe_padding  = pad_r;
   assign pe_if.pe_input_h  = ih;
   assign pe_if.pe_input_w  = iw;
   assign pe_if.pe_output_h = out_h;
   assign pe_if.pe_output_w = out_w;
   assign pe_if.weight_base = wbase;
   assign pe_if.input_base  = ibase;
   assign pe_if.wb_req      = wb_req_r;
   assign pe_if.wb_count    = wb_count_r;
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: layer sizing, error codes, stale pe_done, abort, table protection.
module tb_conv_layer_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [63:0] cfg_wdata = '0;
   logic [3:0]  num_layers = '0;
   logic        sched_start = 1'b0;
   logic        sched_abort = 1'b0;
   logic        busy, sched_done, sched_err;
   logic [1:0]  err_code;
   logic [2:0]  err_layer, cur_layer;

   int n_chk = 0;
   int n_err = 0;
   int dones = 0;
   logic [2:0] st_layer [$];

   conv_layer_scheduler_if pif();

   conv_layer_scheduler #(.MAX_LAYERS(8), .ACC_DEPTH(1024)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .num_layers  (num_layers),
      .sched_start (sched_start),
      .sched_abort (sched_abort),
      .busy        (busy),
      .sched_done  (sched_done),
      .sched_err   (sched_err),
      .err_code    (err_code),
      .err_layer   (err_layer),
      .cur_layer   (cur_layer),
      .pe_if       (pif.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pif.pe_start) st_layer.push_back(cur_layer);
      if (sched_done) dones++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int kh, kw, s, p, ih, iw, wbase, ibase);
      return {16'(ibase), 16'(wbase), 8'(iw), 8'(ih), 4'(p), 4'(s), 4'(kw), 4'(kh)};
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [63:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic go(input logic [3:0] n);
      num_layers = n; sched_start = 1'b1;
      step();
      sched_start = 1'b0;
   endtask

   // 0 pe_start, 1 wb_req, 2 sched_done, 3 sched_err; bounded by a cycle budget.
   task automatic wait_for(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         case (which)
            0:       ok = pif.pe_start;
            1:       ok = pif.wb_req;
            2:       ok = sched_done;
            default: ok = sched_err;
         endcase
         if (ok) break;
         step();
      end
   endtask

   task automatic serve(input string tag, input int oh, input int ow, input int cnt);
      bit ok;
      wait_for(0, ok);
      chk({tag, "_pe_start"}, 64'(ok), 1);
      chk({tag, "_out_h"}, 64'(pif.pe_output_h), 64'(oh));
      chk({tag, "_out_w"}, 64'(pif.pe_output_w), 64'(ow));
      pif.pe_done = 1'b0;
      step();
      chk({tag, "_pe_start_pulse"}, 64'(pif.pe_start), 0);
      repeat (2) step();
      pif.pe_done = 1'b1;
      wait_for(1, ok);
      chk({tag, "_wb_req"}, 64'(ok), 1);
      chk({tag, "_wb_count"}, 64'(pif.wb_count), 64'(cnt));
      pif.wb_ack = 1'b1;
      step();
      pif.wb_ack = 1'b0;
      chk({tag, "_wb_drop"}, 64'(pif.wb_req), 0);
   endtask

   initial begin
      bit ok;
      int d0;
      pif.pe_done = 1'b0;
      pif.wb_ack  = 1'b0;
      repeat (3) step();
      chk("rst_busy", 64'(busy), 0);
      chk("rst_pe_start", 64'(pif.pe_start), 0);
      chk("rst_wb_req", 64'(pif.wb_req), 0);
      chk("rst_err_code", 64'(err_code), 0);
      rst_n = 1'b1;
      step();

      // single 16x16 layer
      wr(0, mk(3, 3, 1, 1, 16, 16, 16'h1111, 16'h2222));
      go(1);
      chk("t1_busy", 64'(busy), 1);
      st_layer.delete();
      serve("t1", 16, 16, 255);
      chk("t1_wbase", 64'(pif.weight_base), 64'h1111);
      chk("t1_ibase", 64'(pif.input_base), 64'h2222);
      wait_for(2, ok);
      chk("t1_done", 64'(ok), 1);
      chk("t1_busy_end", 64'(busy), 0);
      chk("t1_starts", 64'(st_layer.size()), 1);

      // start with an out-of-range layer count is ignored
      go(0);
      chk("n0_ignored", 64'(busy), 0);
      go(9);
      chk("n9_ignored", 64'(busy), 0);

      // three layers in order
      wr(0, mk(3, 3, 1, 0, 8, 8, 0, 0));
      wr(1, mk(3, 3, 2, 1, 32, 32, 0, 0));
      wr(2, mk(1, 1, 1, 0, 4, 4, 0, 0));
      st_layer.delete();
      go(3);
      serve("t2l0", 6, 6, 35);
      serve("t2l1", 16, 16, 255);
      serve("t2l2", 4, 4, 15);
      wait_for(2, ok);
      chk("t2_done", 64'(ok), 1);
      chk("t2_starts", 64'(st_layer.size()), 3);
      for (int i = 0; i < st_layer.size(); i++) chk("t2_order", 64'(st_layer[i]), 64'(i));

      // stride 0 on layer 1
      wr(0, mk(3, 3, 1, 1, 16, 16, 0, 0));
      wr(1, mk(3, 3, 0, 1, 16, 16, 0, 0));
      st_layer.delete();
      go(2);
      serve("t3l0", 16, 16, 255);
      wait_for(3, ok);
      chk("t3_err", 64'(ok), 1);
      chk("t3_code", 64'(err_code), 1);
      chk("t3_layer", 64'(err_layer), 1);
      chk("t3_busy", 64'(busy), 0);
      repeat (4) step();
      chk("t3_starts", 64'(st_layer.size()), 1);

      // kernel larger than padded input
      wr(0, mk(5, 5, 1, 0, 4, 4, 0, 0));
      st_layer.delete();
      go(1);
      wait_for(3, ok);
      chk("t4a_err", 64'(ok), 1);
      chk("t4a_code", 64'(err_code), 2);
      chk("t4a_layer", 64'(err_layer), 0);
      repeat (5) step();
      chk("t4a_code_held", 64'(err_code), 2);

      // 40x40 output exceeds the accumulator
      wr(0, mk(1, 1, 1, 0, 40, 40, 0, 0));
      go(1);
      chk("t4b_code_clr", 64'(err_code), 0);
      wait_for(3, ok);
      chk("t4b_err", 64'(ok), 1);
      chk("t4b_code", 64'(err_code), 3);
      chk("t4ab_starts", 64'(st_layer.size()), 0);

      // stale pe_done level must not complete the layer
      wr(0, mk(3, 3, 1, 1, 16, 16, 0, 0));
      pif.pe_done = 1'b1;
      go(1);
      wait_for(0, ok);
      chk("t5_pe_start", 64'(ok), 1);
      repeat (10) step();
      chk("t5_stale", 64'(pif.wb_req), 0);
      pif.pe_done = 1'b0;
      repeat (2) step();
      pif.pe_done = 1'b1;
      wait_for(1, ok);
      chk("t5_wb_req", 64'(ok), 1);
      pif.wb_ack = 1'b1;
      step();
      pif.wb_ack = 1'b0;
      wait_for(2, ok);
      chk("t5_done", 64'(ok), 1);

      // write alongside an accepted start is dropped, as is a write while busy; then abort in WB
      wr(0, mk(3, 3, 1, 0, 8, 8, 0, 0));
      num_layers = 1; sched_start = 1'b1;
      cfg_we = 1'b1; cfg_addr = 0; cfg_wdata = mk(1, 1, 1, 0, 4, 4, 0, 0);
      step();
      sched_start = 1'b0; cfg_we = 1'b0;
      wait_for(0, ok);
      chk("t6_out_h", 64'(pif.pe_output_h), 6);
      wr(0, mk(1, 1, 1, 0, 4, 4, 0, 0));
      pif.pe_done = 1'b0;
      repeat (2) step();
      pif.pe_done = 1'b1;
      wait_for(1, ok);
      chk("t6_wb_req", 64'(ok), 1);
      d0 = dones;
      sched_abort = 1'b1; pif.wb_ack = 1'b1;
      step();
      sched_abort = 1'b0; pif.wb_ack = 1'b0;
      chk("t6_abort_busy", 64'(busy), 0);
      chk("t6_abort_wb", 64'(pif.wb_req), 0);
      repeat (5) step();
      chk("t6_no_done", 64'(dones), 64'(d0));
      go(1);
      serve("t6r", 6, 6, 35);
      wait_for(2, ok);
      chk("t6r_done", 64'(ok), 1);

      // async reset mid-layer clears state and table
      go(1);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk("t7_rst_busy", 64'(busy), 0);
      step();
      rst_n = 1'b1;
      step();
      go(1);
      wait_for(3, ok);
      chk("t7_tbl_clr", 64'(err_code), 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
